// File: rtl/dvp_if.sv
// DVP camera pin bundle: frame/line syncs, byte clock and pixel byte.
// The transmitter drives it as master; a receiver or bench observes as slave.
interface dvp_if;
   logic       vsync;
   logic       href;
   logic       pclk;
   logic [7:0] dout;

   modport master (output vsync, href, pclk, dout);
   modport slave  (input  vsync, href, pclk, dout);
endinterface

// File: rtl/dvp_pattern_transmitter.sv
// OV7670-style DVP source producing RGB565 test patterns at QVGA timing.
// Optional DVP_TX_PCLK_GATE_EN holds pclk low whenever href is low.
module dvp_pattern_transmitter #(
   parameter int H_ACTIVE      = 320,
   parameter int V_ACTIVE      = 240,
   parameter int H_BLANK       = 144,
   parameter int VSYNC_LINES   = 3,
   parameter int V_BACK_LINES  = 17,
   parameter int V_FRONT_LINES = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] colour,
   dvp_if.master       dvp,
   output logic        frame_done,
   output logic [7:0]  frame_count
);

   localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
   localparam int BW = $clog2(LINE_BYTES + 1);
   localparam int M1 = (VSYNC_LINES > V_BACK_LINES) ?
                       VSYNC_LINES : V_BACK_LINES;
   localparam int M2 = (V_ACTIVE > V_FRONT_LINES) ?
                       V_ACTIVE : V_FRONT_LINES;
   localparam int MAXL = (M1 > M2) ? M1 : M2;
   localparam int LW = $clog2(MAXL + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBACK,
      S_ACTIVE,
      S_VFRONT
   } state_t;

   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic [BW-1:0] byte_q, byte_d;
   logic [LW-1:0] line_q, line_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] colour_q, colour_d;

   logic        vsync_q, vsync_d;
   logic        href_q, href_d;
   logic        pclk_q, pclk_d;
   logic [7:0]  dout_q, dout_d;
   logic        frame_done_q, frame_done_d;
   logic [7:0]  frame_count_q, frame_count_d;

   logic [LW-1:0] last_line;
   logic        start;
   logic [15:0] x;
   logic        y5;
   logic [2:0]  bar;
   logic [15:0] bar_pix;
   logic [15:0] pix;

   always_comb begin
      last_line = '0;
      unique case (state_q)
         S_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
         S_VBACK:  last_line = LW'(V_BACK_LINES - 1);
         S_ACTIVE: last_line = LW'(V_ACTIVE - 1);
         S_VFRONT: last_line = LW'(V_FRONT_LINES - 1);
         default:  last_line = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      byte_d   = byte_q;
      line_d   = line_q;
      sel_d    = sel_q;
      colour_d = colour_q;
      start    = 1'b0;
      if (state_q == S_IDLE) begin
         start = enable;
      end else if (!phase_q) begin
         phase_d = 1'b1;
      end else begin
         phase_d = 1'b0;
         if (byte_q == BW'(LINE_BYTES - 1)) begin
            byte_d = '0;
            if (line_q == last_line) begin
               line_d = '0;
               unique case (state_q)
                  S_VSYNC:  state_d = S_VBACK;
                  S_VBACK:  state_d = S_ACTIVE;
                  S_ACTIVE: state_d = S_VFRONT;
                  S_VFRONT: begin
                     if (enable) start = 1'b1;
                     else state_d = S_IDLE;
                  end
                  default:  state_d = S_IDLE;
               endcase
            end else begin
               line_d = line_q + LW'(1);
            end
         end else begin
            byte_d = byte_q + BW'(1);
         end
      end
      // A new frame re-latches the pattern settings and restarts timing.
      if (start) begin
         state_d  = S_VSYNC;
         phase_d  = 1'b0;
         byte_d   = '0;
         line_d   = '0;
         sel_d    = pattern_sel;
         colour_d = colour;
      end
   end

   always_comb begin
      x = 16'(byte_d >> 1);
      y5 = |(32'(line_d) & 32'h20);
      bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if ({3'b000, x, 3'b000} >= 22'(k * H_ACTIVE))
            bar = bar + 3'd1;
      end
      bar_pix = 16'h0000;
      unique case (bar)
         3'd0: bar_pix = 16'hFFFF;
         3'd1: bar_pix = 16'hFFE0;
         3'd2: bar_pix = 16'h07FF;
         3'd3: bar_pix = 16'h07E0;
         3'd4: bar_pix = 16'hF81F;
         3'd5: bar_pix = 16'hF800;
         3'd6: bar_pix = 16'h001F;
         default: bar_pix = 16'h0000;
      endcase
      pix = 16'h0000;
      unique case (sel_d)
         2'd0: pix = colour_d;
         2'd1: pix = bar_pix;
         2'd2: pix = {x[7:3], x[7:2], x[7:3]};
         default: pix = (x[5] ^ y5) ? 16'hFFFF : 16'h0000;
      endcase
   end

   // Outputs are registered from the upcoming cycle's timing state.
   always_comb begin
      vsync_d = (state_d == S_VSYNC);
      href_d  = (state_d == S_ACTIVE) &&
                (byte_d < BW'(2 * H_ACTIVE));
`ifdef DVP_TX_PCLK_GATE_EN
      pclk_d  = phase_d && href_d;
`else
      pclk_d  = phase_d && (state_d != S_IDLE);
`endif
      dout_d  = 8'h00;
      if (href_d)
         dout_d = byte_d[0] ? pix[7:0] : pix[15:8];
      frame_done_d = (state_d == S_VFRONT) && phase_d &&
                     (byte_d == BW'(LINE_BYTES - 1)) &&
                     (line_d == LW'(V_FRONT_LINES - 1));
      frame_count_d = frame_count_q + {7'd0, frame_done_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         phase_q       <= 1'b0;
         byte_q        <= '0;
         line_q        <= '0;
         sel_q         <= 2'd0;
         colour_q      <= 16'h0000;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         pclk_q        <= 1'b0;
         dout_q        <= 8'h00;
         frame_done_q  <= 1'b0;
         frame_count_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         byte_q        <= byte_d;
         line_q        <= line_d;
         sel_q         <= sel_d;
         colour_q      <= colour_d;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         pclk_q        <= pclk_d;
         dout_q        <= dout_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign dvp.vsync   = vsync_q;
   assign dvp.href    = href_q;
   assign dvp.pclk    = pclk_q;
   assign dvp.dout    = dout_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule
